// File: rtl/hdmi_test_pattern.sv
// hdmi_test_pattern: switch-selected video test patterns with sync/DE delayed one pixel clock to match RGB
module hdmi_test_pattern #(
   parameter int HRES      = 640,
   parameter int VRES      = 480,
   parameter int BAR_WIDTH = 80,
   parameter int BOX_SIZE  = 64
) (
   input  logic       pixel_clock,
   input  logic       reset,
   input  logic [3:0] switch,
   input  logic       horizontal_sync,
   input  logic       vertical_sync,
   input  logic       data_enable,
   output logic       hdmi_hs,
   output logic       hdmi_vs,
   output logic       hdmi_de,
   output logic [7:0] hdmi_r,
   output logic [7:0] hdmi_g,
   output logic [7:0] hdmi_b
);
   localparam logic [11:0] X_MAX    = 12'(HRES - BOX_SIZE);
   localparam logic [11:0] Y_MAX    = 12'(VRES - BOX_SIZE);
   localparam logic [11:0] BAR_LAST = 12'(BAR_WIDTH - 1);
   localparam logic [11:0] BOX      = 12'(BOX_SIZE);
   logic        vs_prev, de_prev, dir_x, dir_y;
   logic        frame_tick, line_end, in_box, next_dir_x, next_dir_y;
   logic [11:0] x_count, y_count, bar_count, box_x, box_y;
   logic [7:0]  frame_count;
   logic [2:0]  bar_index;
   logic [3:0]  active_pattern;
   logic [23:0] bar_rgb, pixel_rgb;
   always_comb begin
      frame_tick = vertical_sync & ~vs_prev;
      line_end   = ~data_enable & de_prev;
      next_dir_x = dir_x ? box_x != X_MAX : box_x == 12'd0;
      next_dir_y = dir_y ? box_y != Y_MAX : box_y == 12'd0;
      in_box     = x_count >= box_x && x_count < box_x + BOX && y_count >= box_y && y_count < box_y + BOX;
      bar_rgb    = {{8{~bar_index[1]}}, {8{~bar_index[2]}}, {8{~bar_index[0]}}};
      pixel_rgb  = active_pattern == 4'd0 ? bar_rgb
                 : active_pattern == 4'd1 ? {24{x_count[5] ^ y_count[5]}}
                 : active_pattern == 4'd2 ? {x_count[7:0], y_count[7:0], frame_count}
                 : active_pattern == 4'd3 ? (in_box ? 24'hffffff : 24'h000080)
                 : 24'h000000;
   end
   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         hdmi_hs        <= 1'b0;
         hdmi_vs        <= 1'b0;
         hdmi_de        <= 1'b0;
         hdmi_r         <= '0;
         hdmi_g         <= '0;
         hdmi_b         <= '0;
         vs_prev        <= 1'b0;
         de_prev        <= 1'b0;
         x_count        <= '0;
         y_count        <= '0;
         frame_count    <= '0;
         bar_count      <= '0;
         bar_index      <= '0;
         active_pattern <= '0;
         box_x          <= '0;
         box_y          <= '0;
         dir_x          <= 1'b1;
         dir_y          <= 1'b1;
      end else begin
         vs_prev                  <= vertical_sync;
         de_prev                  <= data_enable;
         hdmi_hs                  <= horizontal_sync;
         hdmi_vs                  <= vertical_sync;
         hdmi_de                  <= data_enable;
         {hdmi_r, hdmi_g, hdmi_b} <= data_enable ? pixel_rgb : 24'h000000;
         x_count                  <= data_enable ? x_count + 12'd1 : 12'd0;
         bar_count                <= data_enable && bar_count != BAR_LAST ? bar_count + 12'd1 : 12'd0;
         bar_index                <= !data_enable ? 3'd0
                                   : bar_count == BAR_LAST && bar_index != 3'd7 ? bar_index + 3'd1
                                   : bar_index;
         y_count                  <= frame_tick ? 12'd0 : line_end ? y_count + 12'd1 : y_count;
         if (frame_tick) begin
            active_pattern <= switch;
            frame_count    <= frame_count + 8'd1;
            dir_x          <= next_dir_x;
            dir_y          <= next_dir_y;
            box_x          <= next_dir_x ? box_x + 12'd1 : box_x - 12'd1;
            box_y          <= next_dir_y ? box_y + 12'd1 : box_y - 12'd1;
         end
      end
   end
endmodule

// File: tb/tb_hdmi_test_pattern.sv
// tb_hdmi_test_pattern: randomized frames checked cycle by cycle against a coordinate-level pattern model
module tb_hdmi_test_pattern;
   localparam int HRES = 40;
   localparam int VRES = 34;
   localparam int BW   = 5;
   localparam int BOX  = 8;
   logic       pixel_clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] switch = 4'd0;
   logic       horizontal_sync = 1'b0;
   logic       vertical_sync = 1'b0;
   logic       data_enable = 1'b0;
   logic       hdmi_hs, hdmi_vs, hdmi_de;
   logic [7:0] hdmi_r, hdmi_g, hdmi_b;
   logic [26:0] exp_q[$];
   logic [26:0] mon_exp, mon_got;
   logic [23:0] bars [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                             24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};
   int passed = 0;
   int total = 0;
   int drain_fail = 0;
   int ticks = 0;
   int pattern = 0;
   logic last_vs = 1'b0;
   always #5 pixel_clock = ~pixel_clock;
   hdmi_test_pattern #(.HRES(HRES), .VRES(VRES), .BAR_WIDTH(BW), .BOX_SIZE(BOX)) dut (
      .pixel_clock(pixel_clock),
      .reset(reset),
      .switch(switch),
      .horizontal_sync(horizontal_sync),
      .vertical_sync(vertical_sync),
      .data_enable(data_enable),
      .hdmi_hs(hdmi_hs),
      .hdmi_vs(hdmi_vs),
      .hdmi_de(hdmi_de),
      .hdmi_r(hdmi_r),
      .hdmi_g(hdmi_g),
      .hdmi_b(hdmi_b)
   );
   function automatic int tri_pos(input int n, input int m);
      int p;
      p = n % (2 * m);
      return p <= m ? p : 2 * m - p;
   endfunction
   function automatic logic [23:0] model_rgb(input int pat, input int x, input int y, input int n);
      int bx, by;
      bx = tri_pos(n, HRES - BOX);
      by = tri_pos(n, VRES - BOX);
      case (pat)
         0: return bars[x / BW > 7 ? 7 : x / BW];
         1: return ((x / 32) % 2) != ((y / 32) % 2) ? 24'hffffff : 24'h000000;
         2: return {8'(x % 256), 8'(y % 256), 8'(n % 256)};
         3: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 24'hffffff : 24'h000080;
         default: return 24'h000000;
      endcase
   endfunction
   function automatic logic [3:0] rand_sw();
      return $urandom_range(0, 4) == 4 ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
   endfunction
   task automatic drive(input logic rst_v, input logic hs, input logic vs, input logic de, input int x, input int y);
      @(negedge pixel_clock);
      reset = rst_v;
      horizontal_sync = hs;
      vertical_sync = vs;
      data_enable = de;
      if (rst_v) begin
         exp_q.push_back(27'd0);
         ticks = 0;
         pattern = 0;
         last_vs = 1'b0;
      end else begin
         exp_q.push_back({hs, vs, de, de ? model_rgb(pattern, x, y, ticks) : 24'h000000});
         if (vs && !last_vs) begin
            ticks++;
            pattern = int'(switch);
         end
         last_vs = vs;
      end
   endtask
   task automatic reset_line();
      repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, i, 0);
      repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
   endtask
   task automatic frame(input int lines, input int width);
      repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int l = 0; l < lines; l++) begin
         if ($urandom_range(0, 2) == 0) switch = rand_sw();
         repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
         repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
         for (int i = 0; i < width; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, i, l);
         repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      end
   endtask
   always @(posedge pixel_clock) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_exp = exp_q.pop_front();
         mon_got = {hdmi_hs, hdmi_vs, hdmi_de, hdmi_r, hdmi_g, hdmi_b};
         total++;
         if (mon_got === mon_exp) passed++;
         else $display("FAIL pixel_out t=%0t got hs/vs/de=%b%b%b rgb=%06h expected hs/vs/de=%b%b%b rgb=%06h",
                       $time, mon_got[26], mon_got[25], mon_got[24], mon_got[23:0],
                       mon_exp[26], mon_exp[25], mon_exp[24], mon_exp[23:0]);
      end
   end
   initial begin
      int nt, forced;
      reset_line();
      for (int f = 0; f < 300; f++) begin
         if (f == 10) reset_line();
         nt = ticks + 1;
         forced = nt >= 1 && nt <= 3 ? nt - 1
                : (nt >= 25 && nt <= 27) || (nt >= 31 && nt <= 33) ? 3
                : nt >= 254 && nt <= 257 ? 2
                : -1;
         if (forced >= 0) switch = 4'(forced);
         if (forced >= 0 || $urandom_range(0, 19) == 0)
            frame(VRES + $urandom_range(0, 2), HRES + $urandom_range(0, 4));
         else
            frame($urandom_range(1, 3), $urandom_range(1, 12));
      end
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      @(posedge pixel_clock);
      #2;
      if (exp_q.size() != 0) begin
         drain_fail++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, total + drain_fail);
      $finish;
   end
endmodule
